// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: processor opcodes, loader states and the legal-opcode check.
// The CHECK state exists only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

  localparam int PL_OP_W = 3;
  localparam int PL_A_W  = 5;
  localparam int INSTR_W = PL_OP_W + PL_A_W;

  // Processor opcodes; code 7 is the one unused encoding.
  typedef enum logic [PL_OP_W-1:0] {
    OP_STORE = 3'd0,
    OP_LOAD  = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_ADDI  = 3'd4,
    OP_XOR   = 3'd5,
    OP_BNE   = 3'd6
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } loader_state_e;

  function automatic logic op_is_legal(input logic [PL_OP_W-1:0] op);
    case (op)
      OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_ADDI, OP_XOR, OP_BNE: return 1'b1;
      default:                                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/prog_loader_csum.sv
// XOR accumulator over the instruction words written by the loader.
// Instantiated by prog_loader only when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader_csum #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         n_reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] data,
  output logic [W-1:0] sum
);

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum ^ data;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: packs (opcode, operand) tokens into words written to consecutive addresses from 0,
// holding the processor stalled meanwhile. Define PROG_LOADER_CHECKSUM_EN to verify a trailing XOR checksum token.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int OP_W = PL_OP_W,
  parameter int A_W  = PL_A_W
) (
  input  logic                clock,
  input  logic                n_reset,
  input  logic                start,
  input  logic                tok_valid,
  input  logic [OP_W-1:0]     tok_op,
  input  logic [A_W-1:0]      tok_operand,
  input  logic                tok_last,
  output logic                tok_ready,
  output logic [A_W-1:0]      mem_addr,
  output logic [OP_W+A_W-1:0] mem_data,
  output logic                mem_we,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  localparam int W = OP_W + A_W;

  loader_state_e state, state_nx;
  logic [A_W:0]  cnt;
  logic [W-1:0]  word;
  logic          accept;
  logic          overflow;
  logic          wr;
  logic          clr;

  assign word   = {tok_op, tok_operand};
  assign accept = tok_valid && tok_ready;
  // The counter never exceeds 2**A_W, so its top bit alone flags a full memory.
  assign overflow = cnt[A_W];

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [W-1:0] csum;

  prog_loader_csum #(.W(W)) u_csum (
    .clock   (clock),
    .n_reset (n_reset),
    .clear   (clr),
    .en      (wr),
    .data    (word),
    .sum     (csum)
  );
`endif

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    wr       = 1'b0;
    clr      = 1'b0;
    case (state)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_nx = S_WRITE;
          clr      = 1'b1;
        end
      end
      S_WRITE: begin
        if (accept) begin
          if (!op_is_legal(tok_op) || overflow) begin
            state_nx = S_ERROR;
          end else begin
            wr = 1'b1;
            if (tok_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_nx = S_CHECK;
`else
              state_nx = S_DONE;
`endif
            end
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_nx = (word == csum) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake and status are pure state decodes, never a combinational path from tok_valid.
`ifdef PROG_LOADER_CHECKSUM_EN
  assign tok_ready = (state == S_WRITE) || (state == S_CHECK);
`else
  assign tok_ready = (state == S_WRITE);
`endif
  assign cpu_hold = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERROR);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      state  <= state_nx;
      mem_we <= wr;
      if (clr) begin
        cnt <= '0;
      end else if (wr) begin
        cnt      <= cnt + 1'b1;
        mem_addr <= cnt[A_W-1:0];
        mem_data <= word;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised self-checking bench for prog_loader against a token-level reference model.
// Covers the checksum path as well when built with PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;
  import prog_loader_pkg::*;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int DEPTH = 32;
  localparam logic [2:0] BAD_OP = 3'd7;

  typedef struct {
    logic [2:0] op;
    logic [4:0] arg;
    bit         last;
  } tok_t;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic       start = 1'b0;
  logic       tok_valid = 1'b0;
  logic [2:0] tok_op = '0;
  logic [4:0] tok_operand = '0;
  logic       tok_last = 1'b0;
  logic       tok_ready;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_we;
  logic       cpu_hold;
  logic       done;
  logic       error;

  int n_tests = 0;
  int n_fail  = 0;

  tok_t       tq[$];
  logic [4:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic       hold_tr[0:1023];
  int         cyc;
  int         done_n;
  int         done_cyc;
  int         last_cyc;
  int         sent;

  always #5 clock = ~clock;

  prog_loader dut (
    .clock       (clock),
    .n_reset     (n_reset),
    .start       (start),
    .tok_valid   (tok_valid),
    .tok_op      (tok_op),
    .tok_operand (tok_operand),
    .tok_last    (tok_last),
    .tok_ready   (tok_ready),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_we      (mem_we),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .error       (error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and record what the loader did in that cycle.
  task automatic step();
    @(posedge clock);
    #1;
    if (cyc < 1024) hold_tr[cyc] = cpu_hold;
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_data);
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  // Reference: walk the token list with the loader's rules and report writes, tokens consumed and outcome.
  task automatic model(output logic [7:0] ew[$], output int used, output bit ok);
    logic [7:0] x;
    logic [7:0] w;
    bit         in_chk;
    x = '0;
    in_chk = 1'b0;
    ew.delete();
    used = 0;
    ok = 1'b0;
    foreach (tq[i]) begin
      w = {tq[i].op, tq[i].arg};
      used++;
      if (in_chk) begin
        ok = (w == x);
        return;
      end
      if (tq[i].op == BAD_OP || ew.size() == DEPTH) begin
        ok = 1'b0;
        return;
      end
      ew.push_back(w);
      x ^= w;
      if (tq[i].last) begin
        if (CSUM) in_chk = 1'b1;
        else begin
          ok = 1'b1;
          return;
        end
      end
    end
  endtask

  // Start a load, stream tq with random gaps of up to max_gap idle cycles, then compare with the model.
  task automatic play(input string name, input int max_gap);
    logic [7:0] ew[$];
    int         used;
    bit         ok;
    int         gap;
    cyc = 0;
    done_n = 0;
    done_cyc = -1;
    last_cyc = -1;
    sent = 0;
    wa_q.delete();
    wd_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    check({name, ":hold_rise"}, {31'd0, cpu_hold}, 32'd1);
    check({name, ":ready_start"}, {31'd0, tok_ready}, 32'd1);
    check({name, ":err_clear"}, {31'd0, error}, 32'd0);
    foreach (tq[i]) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        tok_op      = 3'($urandom);
        tok_operand = 5'($urandom);
        tok_last    = 1'($urandom);
        step();
      end
      if (!tok_ready) break;
      tok_valid   = 1'b1;
      tok_op      = tq[i].op;
      tok_operand = tq[i].arg;
      tok_last    = tq[i].last;
      step();
      tok_valid = 1'b0;
      tok_last  = 1'b0;
      sent++;
      last_cyc = cyc - 1;
    end
    repeat (4) step();

    model(ew, used, ok);
    check({name, ":consumed"}, sent, used);
    check({name, ":nwrites"}, wa_q.size(), ew.size());
    for (int i = 0; i < wa_q.size() && i < ew.size(); i++) begin
      check({name, ":waddr"}, {27'd0, wa_q[i]}, i);
      check({name, ":wdata"}, {24'd0, wd_q[i]}, {24'd0, ew[i]});
    end
    if (ok) begin
      check({name, ":done_pulses"}, done_n, 1);
      check({name, ":done_cycle"}, done_cyc, last_cyc);
      if (done_cyc >= 0 && done_cyc < 1023)
        check({name, ":hold_fall"}, {31'd0, hold_tr[done_cyc + 1]}, 32'd0);
      check({name, ":idle_hold"}, {31'd0, cpu_hold}, 32'd0);
      check({name, ":idle_err"}, {31'd0, error}, 32'd0);
    end else begin
      check({name, ":done_pulses"}, done_n, 0);
      check({name, ":error"}, {31'd0, error}, 32'd1);
      check({name, ":err_ready"}, {31'd0, tok_ready}, 32'd0);
      check({name, ":err_hold"}, {31'd0, cpu_hold}, 32'd1);
    end
  endtask

  function automatic tok_t mk(input logic [2:0] op, input logic [4:0] arg, input bit last);
    tok_t t;
    t.op = op;
    t.arg = arg;
    t.last = last;
    return t;
  endfunction

  function automatic logic [7:0] xsum(input int upto);
    logic [7:0] x = '0;
    for (int i = 0; i < upto; i++) x ^= {tq[i].op, tq[i].arg};
    return x;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cw;
    int         len;

    #12;
    check("reset:ready", {31'd0, tok_ready}, 32'd0);
    check("reset:we", {31'd0, mem_we}, 32'd0);
    check("reset:hold", {31'd0, cpu_hold}, 32'd0);
    check("reset:done", {31'd0, done}, 32'd0);
    check("reset:error", {31'd0, error}, 32'd0);
    check("reset:addr_data", {19'd0, mem_addr, mem_data}, 32'd0);
    n_reset = 1'b1;
    step();

    // Nominal: LOAD 5, ADD 6, STORE 7 back to back.
    tq.delete();
    tq.push_back(mk(OP_LOAD, 5'd5, 1'b0));
    tq.push_back(mk(OP_ADD, 5'd6, 1'b0));
    tq.push_back(mk(OP_STORE, 5'd7, !CSUM));
    if (CSUM) tq.push_back(mk(3'h0, 5'h1e, 1'b0)); // not a valid checksum unless STORE carried last
    if (CSUM) begin
      tq[2].last = 1'b1;
      cw = xsum(3);
      tq[3] = mk(cw[7:5], cw[4:0], 1'b0);
    end
    play("nominal", 0);

    // Backpressure: idle gaps between tokens.
    tq.delete();
    for (int i = 0; i < 6; i++) tq.push_back(mk(3'($urandom_range(0, 6)), 5'($urandom), i == 5));
    if (CSUM) begin
      cw = xsum(6);
      tq.push_back(mk(cw[7:5], cw[4:0], 1'b0));
    end
    play("gaps", 2);

    // Illegal opcode as the second token, then a fresh load from ERROR.
    tq.delete();
    tq.push_back(mk(OP_LOAD, 5'd5, 1'b0));
    tq.push_back(mk(BAD_OP, 5'd6, 1'b0));
    tq.push_back(mk(OP_STORE, 5'd7, 1'b1));
    play("illegal", 0);
    tq.delete();
    tq.push_back(mk(OP_SUB, 5'd1, 1'b0));
    tq.push_back(mk(OP_XOR, 5'd2, 1'b1));
    if (CSUM) begin
      cw = xsum(2);
      tq.push_back(mk(cw[7:5], cw[4:0], 1'b0));
    end
    play("recover", 0);

    // Illegal opcode carrying tok_last: error wins.
    tq.delete();
    tq.push_back(mk(BAD_OP, 5'd3, 1'b1));
    play("illegal_last", 0);

    // Overflow: 33 legal tokens without tok_last.
    tq.delete();
    for (int i = 0; i < 33; i++) tq.push_back(mk(3'($urandom_range(0, 6)), 5'($urandom), 1'b0));
    play("overflow", 1);

    // Reset mid-load after two tokens.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tok_valid = 1'b1;
      tok_op = OP_ADDI;
      tok_operand = 5'(i + 9);
      step();
    end
    tok_valid = 1'b0;
    #2 n_reset = 1'b0;
    #1;
    check("midreset:ready", {31'd0, tok_ready}, 32'd0);
    check("midreset:we", {31'd0, mem_we}, 32'd0);
    check("midreset:hold", {31'd0, cpu_hold}, 32'd0);
    check("midreset:done_err", {30'd0, done, error}, 32'd0);
    check("midreset:addr_data", {19'd0, mem_addr, mem_data}, 32'd0);
    #1 n_reset = 1'b1;
    repeat (2) step();
    check("midreset:idle_ready", {31'd0, tok_ready}, 32'd0);
    check("midreset:idle_hold", {31'd0, cpu_hold}, 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    tq.delete();
    tq.push_back(mk(OP_LOAD, 5'd5, 1'b0));
    tq.push_back(mk(OP_ADD, 5'd6, 1'b1));
    tq.push_back(mk(3'h3, 5'h03, 1'b0));
    play("csum_ok", 0);
    tq.delete();
    tq.push_back(mk(OP_LOAD, 5'd5, 1'b0));
    tq.push_back(mk(OP_ADD, 5'd6, 1'b1));
    tq.push_back(mk(3'h3, 5'h04, 1'b0));
    play("csum_bad", 0);
`endif

    // Random loads: random length, occasional illegal opcode, random gaps and checksum tokens.
    for (int r = 0; r < 12; r++) begin
      tq.delete();
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        tq.push_back(mk(($urandom_range(0, 9) == 0) ? BAD_OP : 3'($urandom_range(0, 6)),
                        5'($urandom), i == len - 1));
      end
      if (CSUM) begin
        cw = xsum(len) ^ (($urandom_range(0, 1) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7)));
        tq.push_back(mk(cw[7:5], cw[4:0], 1'b0));
      end
      play("random", int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader for the basic processor. It takes a stream of (opcode, operand) tokens over a valid/ready handshake and packs each one into an instruction word. Each word is written to consecutive program-memory addresses starting at 0. While it loads, it holds the processor stalled, so it is the writer at the memory end whose words the processor's instruction decoder later fetches and decodes.

## Interface
- OP_W, 3: opcode field width; matches the processor decoder.
- A_W, 5: operand and address field width; memory depth is 2**A_W words.
- clock  input  1  system clock; all state changes on its rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a load; sampled only in IDLE or ERROR.
- tok_valid  input  1  token present.
- tok_op  input  OP_W  token opcode.
- tok_operand  input  A_W  token operand.
- tok_last  input  1  marks the final program token.
- tok_ready  output  1  loader can accept a token.
- mem_addr  output  A_W  write address.
- mem_data  output  OP_W+A_W  instruction word, {tok_op, tok_operand}.
- mem_we  output  1  write strobe, one cycle per word.
- cpu_hold  output  1  keeps the processor stalled while high.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky load failure.

## Operation
- States: IDLE, WRITE, CHECK (only with the macro), DONE, ERROR.
- IDLE:
  - tok_ready=0, cpu_hold=0.
  - start=1 -> WRITE; clears the word counter (A_W+1 bits) and the checksum.
- WRITE:
  - tok_ready=1, cpu_hold=1.
  - A token is accepted when tok_valid && tok_ready.
  - An accepted token with a legal opcode registers mem_we=1, mem_addr=counter[A_W-1:0] and mem_data={tok_op,tok_operand}, then increments the counter.
  - Legal opcodes are the seven defined in the shared opcode definitions (STORE, LOAD, BNE, ADD, SUB, ADDI, XOR). The remaining 3-bit code is illegal.
- Accepted token with tok_last=1 -> DONE, or -> CHECK when checksum is enabled.
- Error conditions, each going -> ERROR with no write:
  - the accepted token carries the illegal opcode;
  - a token is accepted while counter == 2**A_W (overflow).
- DONE: done=1, cpu_hold=1, tok_ready=0 for one cycle; then -> IDLE.
- ERROR:
  - error=1, cpu_hold=1, tok_ready=0.
  - Exits only on start=1, which goes -> WRITE and clears error, the counter and the checksum.
- start is ignored in WRITE, CHECK and DONE.
- tok_last with an illegal opcode or on overflow: the error takes priority and no write occurs.

## Timing
- Reset values: state IDLE; tok_ready, mem_we, cpu_hold, done and error all 0; mem_addr and mem_data 0; counter and checksum 0.
- Reset asserted mid-load aborts immediately to the reset values. Words already written stay in memory.
- Throughput: one token per cycle while tok_valid is held.
- mem_we, mem_addr and mem_data are registered and appear in the cycle after acceptance. mem_we is 0 in every cycle with no acceptance.
- The last word's mem_we and done are high in the same cycle (no checksum). cpu_hold falls in the cycle after done.
- cpu_hold rises the cycle after start is sampled.
- All outputs come from registers or decode of the state only. tok_ready depends on the state only, never combinationally on tok_valid.

## Configuration
- PROG_LOADER_CHECKSUM_EN defined:
  - Keeps an (OP_W+A_W)-bit XOR of all words written.
  - After tok_last, goes to CHECK with tok_ready=1, cpu_hold=1 and no writes.
  - The next accepted token's {tok_op,tok_operand} is compared to the checksum; it is not opcode-checked and not written.
  - Equal -> DONE; unequal -> ERROR.
- Undefined: no CHECK state and no checksum register; tok_last goes directly to DONE.

## Structure
- Shared package (alongside the processor's opcode definitions):
  - the loader state enum;
  - the legal-opcode check function;
  - the instruction-word width constant OP_W+A_W.
- One sub-module, prog_loader_csum: the XOR accumulator with clear/enable inputs, instantiated only under PROG_LOADER_CHECKSUM_EN.

## Test plan
- Nominal load: start, then LOAD 5, ADD 6, STORE 7 (tok_last on STORE), back to back.
  - Writes addr 0,1,2 on three consecutive cycles.
  - done=1 in the same cycle as the addr-2 write; cpu_hold=0 one cycle later.
- Backpressure: tok_valid low for 2 cycles between tokens -> mem_we=0 in those gaps; addresses stay contiguous.
- Illegal opcode: illegal opcode as the 2nd token -> only addr 0 written; error=1, tok_ready=0; then start -> fresh load from addr 0 succeeds.
- Overflow: A_W=5, 33 tokens with no tok_last -> 32 writes (addr 0-31), then error on the 33rd; no write at addr 0.
- Reset mid-load: n_reset low after 2 tokens -> all outputs 0 asynchronously, state IDLE.
- Checksum (macro defined):
  - words 0x25 and 0x46, then check token 0x63 -> done;
  - check token 0x64 -> error=1 and no third write.
